// File: rtl/hcg_lpi_if.sv
// hcg_lpi_if: LPI bundle between N_PERI clock-gated peripherals and the
// shared handshake sequencer. The sequencer uses the slave modport; the
// peripheral side (or a bench) uses the master modport.
interface hcg_lpi_if #(
    parameter int N_PERI = 4
);
    logic [N_PERI-1:0] cactive_i;
    logic [N_PERI-1:0] csysack_i;
    logic [N_PERI-1:0] lp_en_i;
    logic [N_PERI-1:0] csysreq_o;
    logic [N_PERI-1:0] clk_en_o;
    logic              busy_o;
    logic              timeout_o;
    logic [3:0]        timeout_id_o;

    modport master (
        output cactive_i, csysack_i, lp_en_i,
        input  csysreq_o, clk_en_o, busy_o, timeout_o, timeout_id_o
    );

    modport slave (
        input  cactive_i, csysack_i, lp_en_i,
        output csysreq_o, clk_en_o, busy_o, timeout_o, timeout_id_o
    );
endinterface

// File: rtl/hcg_lpi_seq.sv
// hcg_lpi_seq: shared AXI LPI handshake sequencer. Tracks RUN/STOPPED per
// peripheral, runs one CSYSREQ/CSYSACK handshake at a time (wake requests
// beat sleep requests, round-robin within each class) and drives the HCG
// clock enables.
// Optional feature: define HCG_LPI_SEQ_TIMEOUT_EN to add a handshake timeout
// counter (pulse on timeout_o, ENTRY timeouts fall back to ABORT). Without
// it the engine waits indefinitely and the timeout outputs are tied to 0.
module hcg_lpi_seq #(
    parameter int N_PERI    = 4,
    parameter int HOLDOFF   = 16,
    parameter int TIMEOUT_W = 8
) (
    input logic       clk_i,
    input logic       rst_i,
    hcg_lpi_if.slave  lpi
);
    localparam int CW = $clog2(HOLDOFF + 1);

    typedef logic [N_PERI-1:0] vec_t;
    typedef enum logic [1:0] {ENG_IDLE, ENG_WAKE, ENG_ENTRY, ENG_ABORT} eng_e;

    eng_e          eng_q;
    logic [3:0]    grant_q;
    logic [3:0]    rr_q;
    logic [3:0]    rr_d;
    vec_t          run_q;
    vec_t          req_q;
    vec_t          cand_wake_q;
    vec_t          cand_sleep_q;
    vec_t          cand_sleep_d;
    vec_t          gmask;
    vec_t          deny_mask;
    logic [CW-1:0] idle_q [N_PERI];
    logic [4:0]    wake_pick;
    logic [4:0]    sleep_pick;
    logic          ack_g;
    logic          cact_g;
    logic          to_fire;

    // Round-robin pick: first set bit at index >= ptr, wrapping. Returns
    // {found, index}.
    function automatic logic [4:0] rr_pick(input vec_t req, input logic [3:0] ptr);
        logic [2*N_PERI-1:0] dbl;
        logic [3:0]          off;
        logic [4:0]          sum;
        logic                hit;
        dbl = {req, req} >> ptr;
        off = 4'd0;
        hit = 1'b0;
        for (int i = N_PERI - 1; i >= 0; i--) begin
            if (dbl[i]) begin
                hit = 1'b1;
                off = i[3:0];
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= 5'(N_PERI)) sum = sum - 5'(N_PERI);
        return {hit, sum[3:0]};
    endfunction

    // Granted-peripheral views, arbitration picks and next RR pointer.
    always_comb begin
        gmask      = vec_t'(1) << grant_q;
        ack_g      = |(lpi.csysack_i & gmask);
        cact_g     = |(lpi.cactive_i & gmask);
        wake_pick  = rr_pick(cand_wake_q, rr_q);
        sleep_pick = rr_pick(cand_sleep_q, rr_q);
        rr_d       = (grant_q == 4'(N_PERI - 1)) ? 4'd0 : grant_q + 4'd1;
        deny_mask  = (eng_q == ENG_ENTRY && !ack_g && cact_g) ? gmask : '0;
    end

    // Sleep eligibility: running, idle long enough, and software allows it.
    always_comb begin
        cand_sleep_d = '0;
        for (int i = 0; i < N_PERI; i++) begin
            cand_sleep_d[i] = run_q[i] & lpi.lp_en_i[i] & (idle_q[i] == CW'(HOLDOFF));
        end
    end

    // Candidate registers; held clear while a handshake runs so a finished
    // handshake never re-triggers from stale eligibility.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cand_wake_q  <= '0;
            cand_sleep_q <= '0;
        end else if (eng_q == ENG_IDLE) begin
            cand_wake_q  <= ~run_q & lpi.cactive_i;
            cand_sleep_q <= cand_sleep_d;
        end else begin
            cand_wake_q  <= '0;
            cand_sleep_q <= '0;
        end
    end

    // Per-peripheral idle counters, saturating at HOLDOFF.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_PERI; i++) idle_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_PERI; i++) begin
                if (!run_q[i] || lpi.cactive_i[i] || deny_mask[i]) begin
                    idle_q[i] <= '0;
                end else if (idle_q[i] != CW'(HOLDOFF)) begin
                    idle_q[i] <= idle_q[i] + CW'(1);
                end
            end
        end
    end

    // Handshake engine: arbitration, CSYSREQ drive, RUN/STOPPED tracking.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            eng_q   <= ENG_IDLE;
            grant_q <= 4'd0;
            rr_q    <= 4'd0;
            run_q   <= '0;
            req_q   <= '0;
        end else begin
            case (eng_q)
                ENG_IDLE: begin
                    if (wake_pick[4]) begin
                        grant_q <= wake_pick[3:0];
                        req_q   <= req_q | (vec_t'(1) << wake_pick[3:0]);
                        eng_q   <= ENG_WAKE;
                    end else if (sleep_pick[4]) begin
                        grant_q <= sleep_pick[3:0];
                        req_q   <= req_q & ~(vec_t'(1) << sleep_pick[3:0]);
                        eng_q   <= ENG_ENTRY;
                    end
                end
                ENG_WAKE: begin
                    if (ack_g) begin
                        run_q <= run_q | gmask;
                        rr_q  <= rr_d;
                        eng_q <= ENG_IDLE;
                    end
                end
                ENG_ENTRY: begin
                    if (!ack_g && !cact_g) begin
                        run_q <= run_q & ~gmask;
                        rr_q  <= rr_d;
                        eng_q <= ENG_IDLE;
                    end else if (!ack_g || to_fire) begin
                        req_q <= req_q | gmask;
                        eng_q <= ENG_ABORT;
                    end
                end
                ENG_ABORT: begin
                    if (ack_g) begin
                        rr_q  <= rr_d;
                        eng_q <= ENG_IDLE;
                    end
                end
                default: eng_q <= ENG_IDLE;
            endcase
        end
    end

    assign lpi.csysreq_o = req_q;
    assign lpi.clk_en_o  = run_q | ((eng_q != ENG_IDLE) ? gmask : '0);
    assign lpi.busy_o    = (eng_q != ENG_IDLE);

`ifdef HCG_LPI_SEQ_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TO_MAX = '1;
    localparam logic [TIMEOUT_W-1:0] TO_HIT = TO_MAX - TIMEOUT_W'(1);

    logic [TIMEOUT_W-1:0] to_cnt_q;
    logic                 timeout_q;
    logic [3:0]           timeout_id_q;
    logic                 eng_done;
    logic                 to_hit;

    assign eng_done = ((eng_q == ENG_WAKE || eng_q == ENG_ABORT) && ack_g) ||
                      (eng_q == ENG_ENTRY && !ack_g);
    assign to_hit   = (eng_q != ENG_IDLE) && (to_cnt_q == TO_HIT);
    assign to_fire  = to_hit && !eng_done;

    // Timeout counter restarts on every engine state change and saturates.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            to_cnt_q     <= '0;
            timeout_q    <= 1'b0;
            timeout_id_q <= 4'd0;
        end else begin
            timeout_q <= to_fire;
            if (to_fire) timeout_id_q <= grant_q;
            if (eng_q == ENG_IDLE || eng_done || (to_fire && eng_q == ENG_ENTRY)) begin
                to_cnt_q <= '0;
            end else if (to_cnt_q != TO_MAX) begin
                to_cnt_q <= to_cnt_q + TIMEOUT_W'(1);
            end
        end
    end

    assign lpi.timeout_o    = timeout_q;
    assign lpi.timeout_id_o = timeout_id_q;
`else
    logic unused_cfg;

    assign unused_cfg       = (TIMEOUT_W > 0);
    assign to_fire          = 1'b0;
    assign lpi.timeout_o    = 1'b0;
    assign lpi.timeout_id_o = 4'd0;
`endif
endmodule

// File: tb/tb_hcg_lpi_seq.sv
// tb_hcg_lpi_seq: scoreboard bench for hcg_lpi_seq (N_PERI=4, HOLDOFF=16,
// TIMEOUT_W=4). Expected handshakes {wake, index} are queued as stimulus is
// driven and checked in order as the sequencer starts each one.
module tb_hcg_lpi_seq;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] cact = '0;
    logic [N-1:0] lp_en = '0;
    logic [N-1:0] ack_man = '0;
    logic [N-1:0] ack_auto = '0;
    logic         ack_sel = 1'b0;
    int           total = 0;
    int           bad = 0;
    logic [4:0]   exp_q[$];
    logic [N-1:0] req_prev = '0;
    logic         busy_prev = 1'b0;
    logic         to_seen = 1'b0;

    hcg_lpi_if #(.N_PERI(N)) lpi ();

    assign lpi.cactive_i = cact;
    assign lpi.lp_en_i   = lp_en;
    assign lpi.csysack_i = ack_sel ? ack_auto : ack_man;

    hcg_lpi_seq #(.N_PERI(N), .HOLDOFF(16), .TIMEOUT_W(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .lpi   (lpi)
    );

    always #5 clk = ~clk;

    // Auto-responding peripherals: CSYSACK follows CSYSREQ one cycle later.
    always @(posedge clk) ack_auto <= lpi.csysreq_o;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input int idx, input logic val, input string tag);
        int n;
        n = 0;
        while (lpi.csysreq_o[idx] !== val && n < 60) begin
            step();
            n++;
        end
        chk(tag, lpi.csysreq_o[idx], val);
    endtask

    task automatic drain(input string tag);
        int n;
        int calm;
        n = 0;
        calm = 0;
        while (calm < 3 && n < 400) begin
            step();
            n++;
            if (exp_q.size() == 0 && !lpi.busy_o) calm++;
            else calm = 0;
        end
        chk(tag, calm >= 3, 1'b1);
    endtask

    // Handshake-start monitor: pops the scoreboard when busy_o rises.
    always @(negedge clk) begin
        logic [N-1:0] rose;
        logic [N-1:0] fell;
        logic [4:0]   rec;
        if (rst) begin
            req_prev  = '0;
            busy_prev = 1'b0;
        end else begin
            rose = lpi.csysreq_o & ~req_prev;
            fell = req_prev & ~lpi.csysreq_o;
            if (lpi.timeout_o) to_seen = 1'b1;
            if (lpi.busy_o && !busy_prev) begin
                rec = '0;
                for (int i = 0; i < N; i++) begin
                    if (rose[i]) rec = {1'b1, 4'(i)};
                    else if (fell[i]) rec = {1'b0, 4'(i)};
                end
                chk("start_onehot", $countones(rose | fell), 1);
                if (exp_q.size() == 0) chk("sb_extra", {27'd0, rec}, 32'hffff_ffff);
                else chk("sb_order", {27'd0, rec}, {27'd0, exp_q.pop_front()});
            end
            req_prev  = lpi.csysreq_o;
            busy_prev = lpi.busy_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // reset values
        rst = 1'b1;
        repeat (3) step();
        chk("rst_req", lpi.csysreq_o, 0);
        chk("rst_clken", lpi.clk_en_o, 0);
        chk("rst_busy", lpi.busy_o, 0);
        chk("rst_to", lpi.timeout_o, 0);
        chk("rst_toid", lpi.timeout_id_o, 0);
        rst = 1'b0;
        repeat (3) step();
        chk("post_rst_clken", lpi.clk_en_o, 0);

        // wake periph 2: CSYSREQ two clocks after CACTIVE
        cact = 4'b0100;
        exp_q.push_back({1'b1, 4'd2});
        step();
        chk("wake_lat1", lpi.csysreq_o, 0);
        step();
        chk("wake_req", lpi.csysreq_o, 4'b0100);
        chk("wake_clken", lpi.clk_en_o, 4'b0100);
        chk("wake_busy", lpi.busy_o, 1);
        ack_man = 4'b0100;
        step();
        chk("wake_done", lpi.busy_o, 0);
        chk("wake_run_clken", lpi.clk_en_o, 4'b0100);

        // entry after holdoff; lp_en drop mid-ENTRY does not cancel
        cact  = 4'b0000;
        lp_en = 4'b0100;
        exp_q.push_back({1'b0, 4'd2});
        n = 0;
        while (lpi.csysreq_o[2] && n < 60) begin
            step();
            n++;
        end
        chk("entry_req", lpi.csysreq_o, 0);
        chk("entry_holdoff", n >= 16, 1'b1);
        chk("entry_clken", lpi.clk_en_o, 4'b0100);
        lp_en = 4'b0000;
        step();
        chk("entry_hold_busy", lpi.busy_o, 1);
        chk("entry_hold_clken", lpi.clk_en_o, 4'b0100);
        ack_man = 4'b0000;
        step();
        chk("entry_clken_off", lpi.clk_en_o, 0);
        chk("entry_done", lpi.busy_o, 0);

        // denial
        cact = 4'b0100;
        exp_q.push_back({1'b1, 4'd2});
        wait_req(2, 1'b1, "t4_wake");
        ack_man = 4'b0100;
        step();
        chk("t4_wake_done", lpi.busy_o, 0);
        cact  = 4'b0000;
        lp_en = 4'b0100;
        exp_q.push_back({1'b0, 4'd2});
        wait_req(2, 1'b0, "t4_entry");
        cact    = 4'b0100;
        ack_man = 4'b0000;
        step();
        chk("deny_req", lpi.csysreq_o, 4'b0100);
        chk("deny_busy", lpi.busy_o, 1);
        chk("deny_clken", lpi.clk_en_o, 4'b0100);
        ack_man = 4'b0100;
        step();
        chk("deny_done", lpi.busy_o, 0);
        repeat (5) step();
        chk("deny_run_clken", lpi.clk_en_o, 4'b0100);
        chk("deny_run_idle", lpi.busy_o, 0);

        // fresh reset so the RR pointer starts at 0
        lp_en   = 4'b0000;
        cact    = 4'b0000;
        ack_man = 4'b0000;
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        step();

        // arbitration: bring pointer to 2 with periph 0 RUN and idle
        ack_sel = 1'b1;
        cact = 4'b0001;
        exp_q.push_back({1'b1, 4'd0});
        drain("t5_w0");
        cact = 4'b0011;
        exp_q.push_back({1'b1, 4'd1});
        drain("t5_w1");
        cact  = 4'b0000;
        lp_en = 4'b0010;
        exp_q.push_back({1'b0, 4'd1});
        drain("t5_e1");
        chk("t5_setup", lpi.clk_en_o, 4'b0001);
        lp_en = 4'b0001;
        cact  = 4'b1010;
        exp_q.push_back({1'b1, 4'd3});
        exp_q.push_back({1'b1, 4'd1});
        exp_q.push_back({1'b0, 4'd0});
        drain("t5_arb");
        chk("t5_final", lpi.clk_en_o, 4'b1010);

        // reset mid-ENTRY
        ack_man = lpi.csysreq_o;
        ack_sel = 1'b0;
        cact  = 4'b0010;
        lp_en = 4'b1000;
        exp_q.push_back({1'b0, 4'd3});
        wait_req(3, 1'b0, "t1_entry");
        chk("t1_in_entry", lpi.busy_o, 1);
        rst = 1'b1;
        #1;
        chk("t1_req_rst", lpi.csysreq_o, 0);
        chk("t1_clken_rst", lpi.clk_en_o, 0);
        chk("t1_busy_rst", lpi.busy_o, 0);
        exp_q.delete();
        cact    = 4'b0000;
        lp_en   = 4'b0000;
        ack_man = 4'b0000;
        step();
        rst = 1'b0;
        repeat (4) step();
        chk("t1_busy", lpi.busy_o, 0);
        chk("t1_clken", lpi.clk_en_o, 0);
        chk("t1_req", lpi.csysreq_o, 0);

`ifdef HCG_LPI_SEQ_TIMEOUT_EN
        // ENTRY with ack stuck high: timeout after 15 clocks, then ABORT
        cact = 4'b0100;
        exp_q.push_back({1'b1, 4'd2});
        wait_req(2, 1'b1, "t6_wake");
        ack_man = 4'b0100;
        step();
        cact  = 4'b0000;
        lp_en = 4'b0100;
        exp_q.push_back({1'b0, 4'd2});
        wait_req(2, 1'b0, "t6_entry");
        lp_en = 4'b0000;
        n = 0;
        while (!lpi.timeout_o && n < 40) begin
            step();
            n++;
        end
        chk("t6_cycles", n, 15);
        chk("t6_id", lpi.timeout_id_o, 2);
        chk("t6_abort_req", lpi.csysreq_o[2], 1);
        chk("t6_busy", lpi.busy_o, 1);
        step();
        chk("t6_pulse", lpi.timeout_o, 0);
        chk("t6_idle", lpi.busy_o, 0);
`else
        chk("no_timeout_seen", to_seen, 0);
        chk("no_timeout_id", lpi.timeout_id_o, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
